// File: rtl/xmit_pkg.sv
// -----------------------------------------------------------------------------
// xmit_pkg
//   Shared definitions for the transmit frame feeder:
//     - feeder_state_e : FSM state encoding (IDLE, ACCUM, DROP, SEND)
//     - CTRL_LEN_HI/LO : bounds of the upper length field in f_ctrl_in
//     - LEN_FIELD_W    : width of one length field in f_ctrl_in
//     - DEFAULT_MAX_LEN / DEFAULT_MIN_LEN : default legal frame size range
// -----------------------------------------------------------------------------
package xmit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DROP  = 2'd2,
    ST_SEND  = 2'd3
  } feeder_state_e;

  localparam int CTRL_LEN_HI     = 23;
  localparam int CTRL_LEN_LO     = 12;
  localparam int LEN_FIELD_W     = CTRL_LEN_HI - CTRL_LEN_LO + 1;
  localparam int CTRL_W          = 2 * LEN_FIELD_W;

  localparam int DEFAULT_MAX_LEN = 2048;
  localparam int DEFAULT_MIN_LEN = 64;

endpackage

// File: rtl/xmit_frame_ram.sv
// -----------------------------------------------------------------------------
// xmit_frame_ram
//   Simple dual-port frame buffer, 2**ADDR_W x 8 bits.
//   Synchronous write; registered read (data for rd_addr appears one cycle
//   after it is presented). No reset on the array: the feeder tracks which
//   locations are meaningful through its length counter.
//
//   Ports:
//     clk      in   clock
//     wr_en    in   write strobe
//     wr_addr  in   write address
//     wr_data  in   write byte
//     rd_addr  in   read address (sampled every cycle)
//     rd_data  out  registered read byte
// -----------------------------------------------------------------------------
module xmit_frame_ram #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/xmit_frame_feeder.sv
// -----------------------------------------------------------------------------
// xmit_frame_feeder
//   Store-and-forward stage ahead of the transmitter. Buffers one whole
//   SOF/EOF-framed byte stream, measures its length, rejects runt and oversize
//   frames, then launches it as a control block plus a contiguous byte burst.
//
//   Input handshake: a beat transfers on any cycle where in_valid && in_ready
//   are both high at the rising edge of clk_sys. in_ready is low only while a
//   frame is being launched; in_valid may be held across a not-ready cycle and
//   the beat is simply taken on the next ready cycle. The f_* side has no back
//   pressure: f_rec_data_valid / f_rec_frame_valid are pure qualifiers, and
//   f_data_in / f_ctrl_in read as 0 whenever their qualifier is low.
//
//   Ports:
//     clk_sys            in   system clock
//     reset              in   synchronous, active-high reset
//     in_valid           in   input byte qualifier
//     in_sof / in_eof    in   first / last byte of a frame
//     in_data [7:0]      in   input byte
//     in_hi_priority     in   frame priority, taken on the SOF beat
//     in_ready           out  beat accepted this cycle when in_valid is high
//     m_discard_en       in   transmitter refuses the frame (launch cycle 0)
//     f_data_in [7:0]    out  byte to the transmitter
//     f_ctrl_in [23:0]   out  {length, length}
//     f_rec_data_valid   out  f_data_in valid
//     f_rec_frame_valid  out  f_ctrl_in valid (first CTRL_HOLD burst cycles)
//     f_hi_priority      out  priority of the frame being sent
//     frame_busy         out  a frame is being collected, dropped or sent
//     sent_count [15:0]  out  frames launched (FEEDER_STATS_EN only)
//     drop_count [15:0]  out  frames rejected (FEEDER_STATS_EN only)
//
//   Build option: define FEEDER_STATS_EN to add the saturating sent/drop
//   counters and their ports. Without it the block has no counters.
// -----------------------------------------------------------------------------
module xmit_frame_feeder
  import xmit_pkg::*;
#(
  parameter int MAX_LEN   = DEFAULT_MAX_LEN,
  parameter int MIN_LEN   = DEFAULT_MIN_LEN,
  parameter int ADDR_W    = 11,
  parameter int CTRL_HOLD = 2
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic              in_eof,
  input  logic [7:0]        in_data,
  input  logic              in_hi_priority,
  output logic              in_ready,
  input  logic              m_discard_en,
  output logic [7:0]        f_data_in,
  output logic [CTRL_W-1:0] f_ctrl_in,
  output logic              f_rec_data_valid,
  output logic              f_rec_frame_valid,
  output logic              f_hi_priority,
  output logic              frame_busy
`ifdef FEEDER_STATS_EN
  ,
  output logic [15:0]       sent_count,
  output logic [15:0]       drop_count
`endif
);

  localparam int LW = ADDR_W + 1;
  localparam logic [LW-1:0] LEN_ONE = LW'(1);
  localparam logic [LW-1:0] MAX_L   = LW'(MAX_LEN);
  localparam logic [LW-1:0] MIN_L   = LW'(MIN_LEN);
  localparam logic [LW-1:0] HOLD_L  = LW'(CTRL_HOLD);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  feeder_state_e state, next_state;
  logic [LW-1:0] len, next_len;     // bytes stored; final L while sending
  logic [LW-1:0] cnt, next_cnt;     // burst cycle index while sending
  logic          prio, next_prio;

  logic              accept;
  logic              build;         // this beat is stored as part of a frame
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;

  logic              send_on;
  logic [LEN_FIELD_W-1:0] len_field;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= ST_IDLE;
      len   <= '0;
      cnt   <= '0;
      prio  <= 1'b0;
    end else begin
      state <= next_state;
      len   <= next_len;
      cnt   <= next_cnt;
      prio  <= next_prio;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state, buffer write and read address
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    next_len   = len;
    next_cnt   = cnt;
    next_prio  = prio;
    build      = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    // Outside SEND the read port sits on address 0, so byte 0 is already
    // prefetched during the EOF cycle and lands on launch cycle 0.
    rd_addr    = '0;

    case (state)
      ST_IDLE, ST_ACCUM, ST_DROP: begin
        if (accept) begin
          if (in_sof) begin
            // SOF always (re)starts a frame at address 0, whatever came before.
            build     = 1'b1;
            wr_en     = 1'b1;
            wr_addr   = '0;
            next_len  = LEN_ONE;
            next_prio = in_hi_priority;
            next_state = ST_ACCUM;
          end else if (state == ST_ACCUM) begin
            if (len == MAX_L) begin
              // One byte past the buffer: oversize. If this was also the last
              // byte the frame is finished, otherwise swallow the rest.
              next_state = in_eof ? ST_IDLE : ST_DROP;
            end else begin
              build    = 1'b1;
              wr_en    = 1'b1;
              wr_addr  = ADDR_W'(len);
              next_len = len + LEN_ONE;
            end
          end else if (state == ST_DROP && in_eof) begin
            next_state = ST_IDLE;
          end

          if (build && in_eof) begin
            if (next_len < MIN_L) begin
              next_state = ST_IDLE;
            end else begin
              next_state = ST_SEND;
              next_cnt   = '0;
            end
          end
        end
      end

      ST_SEND: begin
        // Read one ahead of the byte currently on f_data_in.
        rd_addr = ADDR_W'(cnt + LEN_ONE);
        if (cnt == '0 && m_discard_en) begin
          next_state = ST_IDLE;
        end else if (cnt == len - LEN_ONE) begin
          next_state = ST_IDLE;
        end else begin
          next_cnt = cnt + LEN_ONE;
        end
      end

      default: next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame buffer
  // ---------------------------------------------------------------------------
  xmit_frame_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk_sys),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (in_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The discard decision is made combinationally on launch cycle 0 so that a
  // refused frame raises no strobe at all, not even for one cycle.
  assign send_on   = (state == ST_SEND) && !((cnt == '0) && m_discard_en);
  assign len_field = LEN_FIELD_W'(len);

  always_comb begin
    f_rec_data_valid  = send_on;
    f_rec_frame_valid = send_on && (cnt < HOLD_L);
    f_data_in         = send_on ? rd_data : 8'h00;
    f_hi_priority     = send_on && prio;
    f_ctrl_in         = '0;
    if (f_rec_frame_valid) begin
      f_ctrl_in[CTRL_LEN_HI:CTRL_LEN_LO] = len_field;
      f_ctrl_in[CTRL_LEN_LO-1:0]         = len_field;
    end
    in_ready   = (state != ST_SEND);
    frame_busy = (state != ST_IDLE);
  end

`ifdef FEEDER_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  logic        drop_abort;   // SOF cut short an unfinished frame
  logic        drop_end;     // a frame finished without being launched
  logic        drop_refuse;  // transmitter refused the frame at launch
  logic        sent_evt;
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;

  assign drop_abort  = accept && in_sof && (state == ST_ACCUM || state == ST_DROP);
  assign drop_end    = accept && in_eof && (next_state == ST_IDLE) &&
                       (in_sof || state != ST_IDLE);
  assign drop_refuse = (state == ST_SEND) && (cnt == '0) && m_discard_en;
  assign sent_evt    = (state == ST_SEND) && (cnt == '0) && !m_discard_en;
  // A SOF+EOF beat inside ACCUM both aborts the old frame and is itself a runt.
  assign drop_inc    = 2'(drop_abort) + 2'(drop_end) + 2'(drop_refuse);
  assign drop_sum    = {1'b0, drop_count} + 17'(drop_inc);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sent_count <= '0;
      drop_count <= '0;
    end else begin
      if (sent_evt && sent_count != 16'hFFFF) begin
        sent_count <= sent_count + 16'd1;
      end
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule
